// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter.
//   state_e : sequencer states (IDLE -> EXEC -> RESP -> IDLE)
//   ALU_W   : width of the shared carry-lookahead add/sub unit
//   rsp_t   : registered response (sum, carry-out, overflow, owner id)
package alu_share_pkg;

  localparam int ALU_W    = 16;
  // Wide enough for the largest supported requester count (8).
  localparam int RSP_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0]    sum;
    logic                cout;
    logic                ovfl;
    logic [RSP_ID_W-1:0] id;
  } rsp_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index; search wraps upward from here
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner (0 when no request)
//   any   : at least one request is present
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // Modulo keeps the search in range even if ptr exceeds N-1
      // (possible only when N is not a power of two).
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one add/sub unit among NUM_REQ requesters.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub             : 1 = A-B, 0 = A+B
//   add_a/add_b/add_is_sub/add_cin : to the shared adder (registered)
//   add_s/add_cout/add_ovfl        : from the shared adder
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_sum/rsp_cout/rsp_ovfl : registered response payload
//   busy                : an operation is in flight (EXEC or RESP)
//   dbg_state           : current sequencer state
//
// Handshake semantics: a transfer happens on a rising edge where valid
// and ready are both high. req_ready is one-hot and only asserted in
// IDLE for the round-robin winner; requesters not granted must hold.
// rsp_valid stays high and rsp_* stay constant until rsp_ready is seen.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ALU_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_is_sub,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_cout,
  input  logic                     add_ovfl,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_ovfl,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  state_e             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    next_ptr;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_sub;
  rsp_t               rsp_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Pointer moves just past the requester that was served.
  assign next_ptr = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;

  // Grant is combinational so the requester sees its accept in the same
  // cycle; gated by rst_n so nothing is acknowledged while in reset.
  assign req_ready = (state == IDLE && rst_n) ? pick_grant : '0;

  // Adder inputs come straight from the operand registers, which only
  // change on an accept, so the adder never sees mid-operation glitches.
  // The adder inverts B for subtraction; the +1 comes in through cin.
  assign add_a      = op_a;
  assign add_b      = op_b;
  assign add_is_sub = op_sub;
  assign add_cin    = op_sub;

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_ovfl  = rsp_q.ovfl;
  assign rsp_id    = rsp_q.id[ID_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      rsp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_a   <= req_a[pick_idx*WIDTH +: WIDTH];
            op_b   <= req_b[pick_idx*WIDTH +: WIDTH];
            op_sub <= req_sub[pick_idx];
            cur_id <= pick_idx;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_q.sum  <= add_s;
          rsp_q.cout <= add_cout;
          rsp_q.ovfl <= add_ovfl;
          rsp_q.id   <= RSP_ID_W'(cur_id);
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: models the external add/sub unit,
// drives scenario tasks and checks results against arithmetic reference
// functions and a round-robin pointer model.
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [W-1:0]   add_a, add_b, add_s;
  logic           add_is_sub, add_cin, add_cout, add_ovfl;
  logic           rsp_valid, rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout, rsp_ovfl, busy;
  logic [1:0]     dbg_state;

  logic [W-1:0] ra[N];
  logic [W-1:0] rb[N];
  logic         rs[N];

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_sub = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
      req_sub[i]      = rs[i];
    end
  end

  // External carry-lookahead add/sub stand-in: inverts B for subtraction.
  logic [W-1:0] b_eff;
  logic [W:0]   adder_full;
  always_comb begin
    b_eff      = add_is_sub ? ~add_b : add_b;
    adder_full = {1'b0, add_a} + {1'b0, b_eff} + {{W{1'b0}}, add_cin};
  end
  assign add_s    = adder_full[W-1:0];
  assign add_cout = adder_full[W];
  assign add_ovfl = (add_a[W-1] == b_eff[W-1]) && (add_s[W-1] != add_a[W-1]);

  alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_is_sub (add_is_sub),
    .add_cin    (add_cin),
    .add_s      (add_s),
    .add_cout   (add_cout),
    .add_ovfl   (add_ovfl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovfl   (rsp_ovfl),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  function automatic logic [W-1:0] m_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    int r;
    r = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return W'(r & 32'hFFFF);
  endfunction

  function automatic logic m_cout(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub);
    if (sub) return (a >= b);           // carry out of a subtract = no borrow
    return (int'(a) + int'(b)) > 65535;
  endfunction

  function automatic logic m_ovfl(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic int m_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output logic [N-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        g  = req_ready;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ra[i] = 16'h1234; rb[i] = 16'h4321; rs[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid_busy got=%b exp=00", {rsp_valid, busy});
    end
    n_tests++;
    if ({rsp_sum, rsp_cout, rsp_ovfl, rsp_id} !== '0) begin
      n_fail++; $display("FAIL reset_rsp got=%h/%b/%b/%0d exp=0", rsp_sum, rsp_cout, rsp_ovfl, rsp_id);
    end
    n_tests++;
    if ({add_a, add_b, add_is_sub, add_cin} !== '0) begin
      n_fail++; $display("FAIL reset_add got=%h/%h/%b/%b exp=0", add_a, add_b, add_is_sub, add_cin);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] g;
    bit ok;
    int prev_cyc;
    bit ok2;
    prev_cyc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom); rs[i] = 1'($urandom);
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, ok);
      n_tests++;
      if (!ok || g !== (4'b0001 << exp_order[k]) || exp_order[k] != m_pick(4'b1111, m_ptr)) begin
        n_fail++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, g, 4'b0001 << exp_order[k]);
      end
      if (k > 0) begin
        n_tests++;
        if (cyc - prev_cyc != 3) begin
          n_fail++; $display("FAIL rr_interval[%0d] got=%0d exp=3", k, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      m_ptr = (exp_order[k] + 1) % N;
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_rsp(ok2);
    n_tests++;
    if (!ok2 || rsp_id !== IW'(0) || rsp_sum !== m_sum(ra[0], rb[0], rs[0])) begin
      n_fail++; $display("FAIL rr_last_rsp got id=%0d sum=%h exp id=0 sum=%h", rsp_id, rsp_sum,
                         m_sum(ra[0], rb[0], rs[0]));
    end
    wait_idle();
  endtask

  task automatic test_single_add();
    int t0;
    @(posedge clk); #1;
    ra[0] = 16'h7FFF; rb[0] = 16'h0001; rs[0] = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    t0 = cyc;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL add_ready got=%b exp=0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({busy, rsp_valid, add_cin} !== 3'b100) begin
      n_fail++; $display("FAIL add_exec got busy/valid/cin=%b exp=100", {busy, rsp_valid, add_cin});
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || cyc != t0 + 2) begin
      n_fail++; $display("FAIL add_latency got valid=%b dt=%0d exp valid=1 dt=2", rsp_valid, cyc - t0);
    end
    n_tests++;
    if ({rsp_sum, rsp_ovfl, rsp_cout, rsp_id} !== {16'h8000, 1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL add_result got=%h ovfl=%b cout=%b id=%0d exp=8000 1 0 0",
                         rsp_sum, rsp_ovfl, rsp_cout, rsp_id);
    end
    m_ptr = 1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL add_done_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_subtract();
    logic [N-1:0] g;
    bit ok;
    @(posedge clk); #1;
    ra[2] = 16'h0005; rb[2] = 16'h0007; rs[2] = 1'b1;
    req_valid = 4'b0100;
    wait_grant(g, ok);
    n_tests++;
    if (!ok || g !== 4'b0100) begin
      n_fail++; $display("FAIL sub_ready got=%b exp=0100", g);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({add_cin, add_is_sub, add_a, add_b} !== {1'b1, 1'b1, 16'h0005, 16'h0007}) begin
      n_fail++; $display("FAIL sub_exec_bus got cin=%b sub=%b a=%h b=%h exp 1 1 0005 0007",
                         add_cin, add_is_sub, add_a, add_b);
    end
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_sum, rsp_cout, rsp_ovfl, rsp_id} !== {16'hFFFE, 1'b0, 1'b0, 2'd2}) begin
      n_fail++; $display("FAIL sub_result got=%h cout=%b ovfl=%b id=%0d exp=fffe 0 0 2",
                         rsp_sum, rsp_cout, rsp_ovfl, rsp_id);
    end
    m_ptr = 3;
  endtask

  task automatic test_wrap();
    logic [N-1:0] g;
    bit ok;
    int e;
    @(posedge clk); #1;
    ra[1] = 16'hFFFF; rb[1] = 16'h0001; rs[1] = 1'b0;
    req_valid = 4'b0010;
    e = m_pick(4'b0010, m_ptr);
    wait_grant(g, ok);
    n_tests++;
    if (!ok || g !== (4'b0001 << e)) begin
      n_fail++; $display("FAIL wrap_ready got=%b exp=%b", g, 4'b0001 << e);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(ok);
    n_tests++;
    if (!ok || {rsp_sum, rsp_cout, rsp_ovfl, rsp_id} !== {16'h0000, 1'b1, 1'b0, 2'd1}) begin
      n_fail++; $display("FAIL wrap_result got=%h cout=%b ovfl=%b id=%0d exp=0000 1 0 1",
                         rsp_sum, rsp_cout, rsp_ovfl, rsp_id);
    end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] g;
    bit ok;
    int e;
    logic [W-1:0] hold_sum;
    logic [W-1:0] exp_sum;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom); rs[i] = 1'($urandom);
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    e = m_pick(4'b0010, m_ptr);
    wait_grant(g, ok);
    n_tests++;
    if (!ok || g !== (4'b0001 << e)) begin
      n_fail++; $display("FAIL bp_ready got=%b exp=%b", g, 4'b0001 << e);
    end
    @(posedge clk); #1;
    req_valid = 4'b0001;        // another requester waits during back-pressure
    wait_rsp(ok);
    exp_sum = m_sum(ra[1], rb[1], rs[1]);
    n_tests++;
    if (!ok || rsp_sum !== exp_sum || rsp_id !== IW'(e)) begin
      n_fail++; $display("FAIL bp_result got=%h id=%0d exp=%h id=%0d", rsp_sum, rsp_id, exp_sum, e);
    end
    hold_sum = exp_sum;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, busy, req_ready} !== {1'b1, 1'b1, 4'b0000} || rsp_sum !== hold_sum ||
          rsp_id !== IW'(e)) begin
        n_fail++; $display("FAIL bp_hold[%0d] got valid=%b busy=%b ready=%b sum=%h id=%0d exp 1 1 0000 %h %0d",
                           k, rsp_valid, busy, req_ready, rsp_sum, rsp_id, hold_sum, e);
      end
    end
    rsp_ready = 1'b1;
    m_ptr = (e + 1) % N;
    e = m_pick(4'b0001, m_ptr);
    @(negedge clk);
    n_tests++;
    if (req_ready !== (4'b0001 << e)) begin
      n_fail++; $display("FAIL bp_release_accept got=%b exp=%b", req_ready, 4'b0001 << e);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(ok);
    exp_sum = m_sum(ra[0], rb[0], rs[0]);
    n_tests++;
    if (!ok || rsp_sum !== exp_sum || rsp_id !== IW'(e)) begin
      n_fail++; $display("FAIL bp_next_result got=%h id=%0d exp=%h id=%0d", rsp_sum, rsp_id, exp_sum, e);
    end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    logic [N-1:0] mask;
    bit ok;
    int e;
    int d;
    logic [W-1:0] es;
    logic ec, eo;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        ra[i] = W'($urandom); rb[i] = W'($urandom); rs[i] = 1'($urandom);
      end
      if (t % 5 == 0) begin          // bias some operands toward the extremes
        ra[0] = 16'h8000; rb[0] = 16'h0001; rs[0] = 1'b1;
      end
      mask = N'($urandom_range(1, 15));
      rsp_ready = 1'b0;
      req_valid = mask;
      e  = m_pick(mask, m_ptr);
      es = m_sum(ra[e], rb[e], rs[e]);
      ec = m_cout(ra[e], rb[e], rs[e]);
      eo = m_ovfl(ra[e], rb[e], rs[e]);
      wait_grant(g, ok);
      n_tests++;
      if (!ok || g !== (4'b0001 << e)) begin
        n_fail++; $display("FAIL rand_grant[%0d] mask=%b ptr=%0d got=%b exp=%b", t, mask, m_ptr, g, 4'b0001 << e);
      end
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(ok);
      n_tests++;
      if (!ok || {rsp_sum, rsp_cout, rsp_ovfl, rsp_id} !== {es, ec, eo, IW'(e)}) begin
        n_fail++; $display("FAIL rand_rsp[%0d] got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", t,
                           rsp_sum, rsp_cout, rsp_ovfl, rsp_id, es, ec, eo, e);
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_sum !== es) begin
        n_fail++; $display("FAIL rand_stable[%0d] got valid=%b sum=%h exp 1 %h", t, rsp_valid, rsp_sum, es);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      m_ptr = (e + 1) % N;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] g;
    bit ok;
    logic [W-1:0] es;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom); rs[i] = 1'($urandom);
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    wait_grant(g, ok);
    @(posedge clk); #1;         // now in EXEC
    req_valid = 4'b1000;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, busy, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_ctrl got ready=%b busy=%b valid=%b exp 0", req_ready, busy, rsp_valid);
    end
    n_tests++;
    if ({add_a, add_b, add_is_sub, add_cin, rsp_sum, rsp_cout, rsp_ovfl, rsp_id} !== '0) begin
      n_fail++; $display("FAIL midrst_data got add=%h/%h/%b/%b rsp=%h/%b/%b/%0d exp 0",
                         add_a, add_b, add_is_sub, add_cin, rsp_sum, rsp_cout, rsp_ovfl, rsp_id);
    end
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== (4'b0001 << m_pick(4'b1000, m_ptr))) begin
      n_fail++; $display("FAIL midrst_first_grant got=%b exp=1000", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    es = m_sum(ra[3], rb[3], rs[3]);
    wait_rsp(ok);
    n_tests++;
    if (!ok || rsp_id !== IW'(3) || rsp_sum !== es) begin
      n_fail++; $display("FAIL midrst_rsp got id=%0d sum=%h exp id=3 sum=%h", rsp_id, rsp_sum, es);
    end
    m_ptr = 0;
    wait_idle();
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; rs[i] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_single_add();
    test_subtract();
    test_wrap();
    test_back_pressure();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 16-bit carry-lookahead add/subtract unit among `NUM_REQ` requesters (address generation, branch target, PC increment, and similar). It accepts one operation per grant and drives the shared adder from registered operands. It captures sum, carry-out and overflow into a result register, then returns them on a single tagged response channel. It sits between the requesting datapath blocks and the one adder instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: operand width; must match the adder.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NUM_REQ`: per-requester operation valid.
- `req_ready`, output, `NUM_REQ`: one-hot accept; at most one bit high.
- `req_a`, input, `NUM_REQ*WIDTH`: operand A, requester i in slice [i*WIDTH +: WIDTH].
- `req_b`, input, `NUM_REQ*WIDTH`: operand B, same packing as `req_a`.
- `req_sub`, input, `NUM_REQ`: 1 = A−B, 0 = A+B.
- `add_a`, output, `WIDTH`: to shared adder A.
- `add_b`, output, `WIDTH`: to shared adder B (uninverted; the adder inverts).
- `add_is_sub`, output, 1: to adder isSub.
- `add_cin`, output, 1: to adder Cin.
- `add_s`, input, `WIDTH`: adder sum.
- `add_cout`, input, 1: adder carry-out.
- `add_ovfl`, input, 1: adder signed overflow.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_id`, output, `ID_W`: requester that owns the result.
- `rsp_sum`, output, `WIDTH`: registered sum.
- `rsp_cout`, output, 1: registered carry-out.
- `rsp_ovfl`, output, 1: registered overflow.
- `busy`, output, 1: high in EXEC or RESP.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick the winner. Search starts at `rr_ptr` and wraps upward to the first valid requester.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - Latch the winner's A, B and sub into the operand registers. Latch the winner index into `cur_id`.
  - Next state: EXEC.
  - If no `req_valid` is high, stay in IDLE with `req_ready` = 0.
- **EXEC:**
  - Drive `add_a`/`add_b`/`add_is_sub` from the operand registers.
  - Drive `add_cin` = the operand sub bit. Two's-complement subtraction is A + ~B + 1; the adder performs the inversion, this block supplies the +1.
  - At the clock edge, capture `add_s`/`add_cout`/`add_ovfl` into the result registers.
  - Next state: RESP.
- **RESP:**
  - `rsp_valid` = 1, `rsp_id` = `cur_id`; the result registers stay stable.
  - When `rsp_ready` = 1: set `rr_ptr` ← (`cur_id`+1) mod `NUM_REQ`, go to IDLE.
  - Otherwise hold; `rsp_*` must not change.
- **Adder outputs outside EXEC:** `add_*` keep the operand-register values, which do not change outside IDLE, so the adder sees no glitches. `add_cin` = `add_is_sub` at all times.
- **Width rules:**
  - Sum wraps modulo 2^WIDTH.
  - `rsp_cout` is the raw adder carry. For subtraction, `rsp_cout` = 1 means no borrow.
  - `rsp_ovfl` is passed through unmodified.
- **Request inputs:** `req_valid` may drop without handshake; only the accepted cycle matters. Requests not granted receive no ack and must hold.

## Timing
- **Reset (async assert, release synchronous to `clk`):**
  - state = IDLE, `rr_ptr` = 0.
  - Operand, result and `cur_id` registers = 0.
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0.
  - `rsp_sum`/`rsp_cout`/`rsp_ovfl`/`rsp_id` = 0.
  - `add_*` = 0.
- **Latency:** accept in cycle T; `rsp_valid` rises at T+2. Minimum issue interval is 3 cycles (accept, exec, resp with `rsp_ready` = 1); the next accept is at T+3.
- **Back-pressure:** RESP holds indefinitely; no new accept while `busy`.
- **Simultaneous requests:** exactly one grant per accept cycle. Worst-case wait for any requester is `NUM_REQ`−1 other grants.
- **`rr_ptr` wrap-around:** `rr_ptr` advances only on the response handshake; from `NUM_REQ`−1 it wraps to 0.
- **Reset mid-operation:** the in-flight operation is dropped with no response, and `rr_ptr` returns to 0.

## Structure
- **Shared package `alu_share_pkg`:**
  - state enum `{IDLE, EXEC, RESP}`.
  - `ALU_W` = 16.
  - response struct (sum, cout, ovfl, id).
- **Sub-module `rr_pick`:** purely combinational. Inputs: request vector and pointer. Outputs: one-hot grant and index. Reusable by other shared-resource arbiters.
- **Adder instance:** not instantiated here; the top level connects `add_*` to the existing CLA add/sub.

## Test plan
- **Single add:** req0 A=0x7FFF, B=0x0001, sub=0 → `req_ready[0]` same cycle. At T+2: `rsp_sum`=0x8000, `rsp_ovfl`=1, `rsp_cout`=0, `rsp_id`=0.
- **Subtract:** req2 A=0x0005, B=0x0007, sub=1 → `add_cin`=1 in EXEC; `rsp_sum`=0xFFFE, `rsp_cout`=0, `rsp_ovfl`=0, `rsp_id`=2.
- **Round-robin:** all 4 `req_valid` held high, `rsp_ready`=1 → grant order 0,1,2,3,0. Accept cycles are every 3 clocks.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready` all 0, `busy`=1. Releasing `rsp_ready` leads to the next accept 1 cycle later.
- **Reset mid-op:** assert `rst_n`=0 in EXEC → all outputs 0 immediately. After release, with req3 valid, the first grant is 3 (pointer from 0 wraps to the first valid requester).
- **Wrap arithmetic:** A=0xFFFF, B=0x0001, sub=0 → `rsp_sum`=0x0000, `rsp_cout`=1, `rsp_ovfl`=0.
